// File: rtl/rv32_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the rv32 core.
// Fetches over a valid/ready port, gates rf_wen to writeback and halts on trap.
module rv32_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h8000_0000,
  parameter logic [31:0] PC_INCREMENT  = 32'd4,
  parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  output logic        rf_wen,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_WAIT      = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] TRAP_EBREAK  = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [1:0]  trap_r;
  logic [31:0] cycle_r;
  logic [31:0] instret_r;

  // Sequencer state, PC, instruction register and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= 8'd0;
      pc_r       <= RESET_VECTOR;
      inst_r     <= 32'd0;
      trap_r     <= TRAP_EBREAK;
      cycle_r    <= 32'd0;
      instret_r  <= 32'd0;
    end else begin
      if (state_r != S_HALT) begin
        cycle_r <= cycle_r + 32'd1;
      end
      case (state_r)
        S_FETCH: begin
          if (run_en && imem_req_ready) begin
            state_r    <= S_WAIT;
            wait_cnt_r <= 8'd0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_r  <= imem_rsp_data;
            state_r <= S_DECODE;
          end else if (wait_cnt_r == FETCH_TIMEOUT - 8'd1) begin
            // This is the FETCH_TIMEOUT-th silent WAIT cycle.
            trap_r  <= TRAP_TIMEOUT;
            state_r <= S_HALT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            trap_r  <= TRAP_ILLEGAL;
            state_r <= S_HALT;
          end else if (dec_ebreak) begin
            trap_r  <= TRAP_EBREAK;
            state_r <= S_HALT;
          end else begin
            state_r <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          state_r <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc_r      <= pc_r + PC_INCREMENT;
          instret_r <= instret_r + 32'd1;
          state_r   <= S_FETCH;
        end
        S_HALT: begin
          state_r <= S_HALT;
        end
        default: begin
          // Unreachable encodings stop the core rather than run undefined code.
          state_r <= S_HALT;
        end
      endcase
    end
  end

  // Request valid follows run_en directly so a fetch issues the cycle run_en rises.
  assign imem_req_valid = (state_r == S_FETCH) && run_en;
  assign imem_addr      = pc_r;
  assign pc             = pc_r;
  assign inst           = inst_r;
  assign rf_wen         = (state_r == S_WRITEBACK);
  assign retire         = (state_r == S_WRITEBACK);
  assign halted         = (state_r == S_HALT);
  assign trap_cause     = trap_r;
  assign cycle_count    = cycle_r;
  assign instret        = instret_r;

endmodule

// File: tb/tb_rv32_sequencer.sv
// Directed bench for rv32_sequencer; inputs change and outputs are sampled on negedge.
module tb_rv32_sequencer;

  logic        clk;
  logic        rst;
  logic        run_en;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_ebreak;
  logic        dec_illegal;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        rf_wen;
  logic        retire;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_count;
  logic [31:0] instret;

  logic        w_imem_req_valid;
  logic [31:0] w_imem_addr;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_rf_wen;
  logic        w_retire;
  logic        w_halted;
  logic [1:0]  w_trap_cause;
  logic [31:0] w_cycle_count;
  logic [31:0] w_instret;

  int n_cmp;
  int n_bad;

  rv32_sequencer #(.RESET_VECTOR(32'h8000_0000), .PC_INCREMENT(32'd4), .FETCH_TIMEOUT(8'd8)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(inst), .pc(pc), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .rf_wen(rf_wen), .retire(retire), .halted(halted), .trap_cause(trap_cause),
    .cycle_count(cycle_count), .instret(instret)
  );

  // Second instance starting at the top of the address space to exercise PC wrap.
  rv32_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .PC_INCREMENT(32'd4), .FETCH_TIMEOUT(8'd8)) dut_w (
    .clk(clk), .rst(rst), .run_en(run_en),
    .imem_req_valid(w_imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(w_inst), .pc(w_pc), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .rf_wen(w_rf_wen), .retire(w_retire), .halted(w_halted), .trap_cause(w_trap_cause),
    .cycle_count(w_cycle_count), .instret(w_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run_en = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0; dec_ebreak = 1'b0; dec_illegal = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Zero-wait fetch of one word; returns at the negedge of the DECODE cycle.
  task automatic issue_zero_wait(input logic [31:0] word);
    run_en = 1'b1; imem_req_ready = 1'b1;
    step();
    run_en = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = word;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (pc !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h8000_0000); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_cmp++; if (halted !== 1'b0 || trap_cause !== 2'b00) begin n_bad++; $display("FAIL reset_halt: got %b/%b want 0/00", halted, trap_cause); end
    n_cmp++; if (cycle_count !== 32'd0 || instret !== 32'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_count, instret); end
    n_cmp++; if (imem_req_valid !== 1'b0 || rf_wen !== 1'b0 || retire !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b%b%b want 000", imem_req_valid, rf_wen, retire); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] words [3];
    logic [31:0] exp_addr;
    int rf_cnt;
    words[0] = 32'h0010_0093; words[1] = 32'h0020_8113; words[2] = 32'h0031_0193;
    rf_cnt = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_en = 1'b1; imem_req_ready = 1'b1; #1;
      exp_addr = 32'h8000_0000 + 32'(i * 4);
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr) begin n_bad++; $display("FAIL zw_fetch%0d: got %b/%h want 1/%h", i, imem_req_valid, imem_addr, exp_addr); end
      step();
      run_en = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = words[i];
      n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL zw_wait_retire%0d: got %b want 0", i, retire); end
      step();
      imem_rsp_valid = 1'b0;
      n_cmp++; if (inst !== words[i]) begin n_bad++; $display("FAIL zw_inst%0d: got %h want %h", i, inst, words[i]); end
      step();
      n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL zw_exec_wen%0d: got %b want 0", i, rf_wen); end
      step();
      if (rf_wen === 1'b1) rf_cnt++;
      n_cmp++; if (rf_wen !== 1'b1 || retire !== 1'b1) begin n_bad++; $display("FAIL zw_wb%0d: got %b/%b want 1/1", i, rf_wen, retire); end
      step();
    end
    n_cmp++; if (rf_cnt !== 3) begin n_bad++; $display("FAIL zw_wen_count: got %0d want 3", rf_cnt); end
    n_cmp++; if (instret !== 32'd3 || cycle_count !== 32'd15) begin n_bad++; $display("FAIL zw_counters: got %0d/%0d want 3/15", instret, cycle_count); end
    n_cmp++; if (pc !== 32'h8000_000C) begin n_bad++; $display("FAIL zw_pc: got %h want 8000000c", pc); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      run_en = (c <= 4); imem_req_ready = (c == 4);
      imem_rsp_valid = (c == 7); imem_rsp_data = 32'h0010_0093;
      #1;
      if (c <= 4) begin
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL stall_req_c%0d: got %b/%h want 1/80000000", c, imem_req_valid, imem_addr); end
      end
      if (c == 9) begin
        n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL stall_early_retire: got %b want 0", retire); end
      end
      if (c == 10) begin
        n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL stall_retire: got %b want 1", retire); end
      end
      step();
    end
    imem_rsp_valid = 1'b0;
    n_cmp++; if (cycle_count !== 32'd11 || instret !== 32'd1 || pc !== 32'h8000_0004) begin n_bad++; $display("FAIL stall_end: got %0d/%0d/%h want 11/1/80000004", cycle_count, instret, pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    run_en = 1'b1; imem_req_ready = 1'b1;
    step();
    run_en = 1'b0; imem_req_ready = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL to_early_halt_c%0d: got %b want 0", c, halted); end
      step();
    end
    n_cmp++; if (halted !== 1'b1 || trap_cause !== 2'b10) begin n_bad++; $display("FAIL to_halt: got %b/%b want 1/10", halted, trap_cause); end
    n_cmp++; if (pc !== 32'h8000_0000 || instret !== 32'd0 || cycle_count !== 32'd9) begin n_bad++; $display("FAIL to_state: got %h/%0d/%0d want 80000000/0/9", pc, instret, cycle_count); end
    run_en = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step(); step(); step();
    n_cmp++; if (cycle_count !== 32'd9 || imem_req_valid !== 1'b0 || inst !== 32'h0 || halted !== 1'b1) begin n_bad++; $display("FAIL to_frozen: got %0d/%b/%h/%b want 9/0/0/1", cycle_count, imem_req_valid, inst, halted); end
  endtask

  task automatic test_illegal();
    do_reset();
    issue_zero_wait(32'hFFFF_FFFF);
    dec_illegal = 1'b1; dec_ebreak = 1'b1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL ill_decode_wen: got %b want 0", rf_wen); end
    step();
    dec_illegal = 1'b0; dec_ebreak = 1'b0;
    n_cmp++; if (halted !== 1'b1 || trap_cause !== 2'b01) begin n_bad++; $display("FAIL ill_trap: got %b/%b want 1/01", halted, trap_cause); end
    n_cmp++; if (pc !== 32'h8000_0000 || instret !== 32'd0 || inst !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ill_state: got %h/%0d/%h want 80000000/0/ffffffff", pc, instret, inst); end
    step(); step();
    n_cmp++; if (rf_wen !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) begin n_bad++; $display("FAIL ill_sticky: got %b/%b/%b want 0/0/1", rf_wen, retire, halted); end
  endtask

  task automatic test_ebreak();
    do_reset();
    issue_zero_wait(32'h0010_0073);
    dec_ebreak = 1'b1;
    step();
    dec_ebreak = 1'b0;
    n_cmp++; if (halted !== 1'b1 || trap_cause !== 2'b00) begin n_bad++; $display("FAIL ebr_trap: got %b/%b want 1/00", halted, trap_cause); end
    n_cmp++; if (pc !== 32'h8000_0000 || cycle_count !== 32'd3 || instret !== 32'd0) begin n_bad++; $display("FAIL ebr_state: got %h/%0d/%0d want 80000000/3/0", pc, cycle_count, instret); end
  endtask

  task automatic test_run_gate();
    do_reset();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; imem_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL gate_valid_c%0d: got %b want 0", c, imem_req_valid); end
      step();
      imem_rsp_valid = 1'b0;
    end
    n_cmp++; if (cycle_count !== 32'd6 || inst !== 32'h0 || pc !== 32'h8000_0000) begin n_bad++; $display("FAIL gate_state: got %0d/%h/%h want 6/0/80000000", cycle_count, inst, pc); end
    run_en = 1'b1; #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL gate_rise: got %b want 1", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL gate_accepted: got %b want 0", imem_req_valid); end
    run_en = 1'b0; imem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_zero_wait(32'h0010_0093);
    step();
    n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL rmid_exec_wen: got %b want 0", rf_wen); end
    rst = 1'b1;
    step();
    n_cmp++; if (pc !== 32'h8000_0000 || inst !== 32'h0 || rf_wen !== 1'b0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_state: got %h/%h/%b/%b want 80000000/0/0/0", pc, inst, rf_wen, imem_req_valid); end
    n_cmp++; if (cycle_count !== 32'd0 || instret !== 32'd0) begin n_bad++; $display("FAIL rmid_counters: got %0d/%0d want 0/0", cycle_count, instret); end
    rst = 1'b0;
    step();
    n_cmp++; if (rf_wen !== 1'b0 || cycle_count !== 32'd1) begin n_bad++; $display("FAIL rmid_after: got %b/%0d want 0/1", rf_wen, cycle_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    n_cmp++; if (w_imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_start: got %h want fffffffc", w_imem_addr); end
    issue_zero_wait(32'h0010_0093);
    step(); step(); step();
    n_cmp++; if (w_pc !== 32'h0 || w_imem_addr !== 32'h0 || w_instret !== 32'd1) begin n_bad++; $display("FAIL wrap_pc: got %h/%h/%0d want 0/0/1", w_pc, w_imem_addr, w_instret); end
    n_cmp++; if (pc !== 32'h8000_0004) begin n_bad++; $display("FAIL wrap_main_pc: got %h want 80000004", pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_timeout();
    test_illegal();
    test_ebreak();
    test_run_gate();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
